axi_ddr_slave: RTL and testbench

AXI_DDR_SLAVE -- requirements
Module: axi_ddr_slave

---
 rtl/axi_ddr_slave_pkg.sv | 42 ++++
 rtl/axi_ddr_slave_addr_gen.sv | 84 ++++++++
 rtl/axi_ddr_slave.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_axi_ddr_slave.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ddr_slave_pkg.sv
// Shared types and encodings for the AXI4 DDR-port responder.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package axi_ddr_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_WRESP = 2'd2,
        ST_RDATA = 2'd3
    } state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Severity ordering OKAY < SLVERR < DECERR matches the numeric encoding;
    // EXOKAY is never produced by this block, so a numeric max is sufficient.
    function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Burst attributes we do not honour: beat sizes wider than the data bus
    // and burst types other than FIXED/INCR (WRAP and the reserved encoding).
    function automatic logic attr_bad(input logic [2:0] size, input logic [1:0] burst);
        return (size > 3'd2) || ((burst != BURST_FIXED) && (burst != BURST_INCR));
    endfunction

    // Per-beat response: a decode miss outranks an attribute error.
    function automatic logic [1:0] beat_resp(input logic hit, input logic attr_err);
        if (!hit) begin
            return RESP_DECERR;
        end
        return attr_err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_ddr_slave_addr_gen.sv
// Burst address/beat tracker with window decode for the current and next beat.
// Latency: decode outputs are combinational; counters update on the clock edge.
// Backpressure: advances only when the parent pulses adv on a completed beat.
module axi_ddr_slave_addr_gen
    import axi_ddr_slave_pkg::*;
#(
    parameter int                  AW        = 32,
    parameter int                  MEM_WORDS = 1024,
    parameter logic [AW-1:0]       BASE_ADDR = 32'h1000_0000,
    parameter int                  IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             adv,
    input  logic [AW-1:0]    ld_addr,
    input  logic [2:0]       ld_size,
    input  logic [1:0]       ld_burst,
    output logic [7:0]       beat_cnt,
    output logic [7:0]       beat_cnt_nxt,
    output logic             cur_hit,
    output logic [IDX_W-1:0] cur_idx,
    output logic             nxt_hit,
    output logic [IDX_W-1:0] nxt_idx
);

    localparam logic [AW-1:0] WIN_WORDS = AW'(MEM_WORDS);

    logic [AW-1:0] addr_q,  addr_d;
    logic [2:0]    size_q,  size_d;
    logic [1:0]    burst_q, burst_d;
    logic [7:0]    beat_q,  beat_d;
    logic [AW-1:0] cur_word, nxt_word;

    // Next address/beat: reload on a new burst, otherwise step by the beat size
    // unless the burst is FIXED (WRAP and reserved types walk like INCR).
    always_comb begin
        addr_d  = addr_q;
        size_d  = size_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        if (load) begin
            addr_d  = ld_addr;
            size_d  = ld_size;
            burst_d = ld_burst;
            beat_d  = 8'd0;
        end else if (adv) begin
            beat_d = beat_q + 8'd1;
            if (burst_q != BURST_FIXED) begin
                addr_d = addr_q + (AW'(1) << size_q);
            end
        end
    end

    // Window decode for the beat being serviced now (writes) and the beat
    // that will be presented next cycle (read preload).
    always_comb begin
        cur_word = (addr_q - BASE_ADDR) >> 2;
        nxt_word = (addr_d - BASE_ADDR) >> 2;
        cur_hit  = (addr_q >= BASE_ADDR) && (cur_word < WIN_WORDS);
        nxt_hit  = (addr_d >= BASE_ADDR) && (nxt_word < WIN_WORDS);
        cur_idx  = cur_word[IDX_W-1:0];
        nxt_idx  = nxt_word[IDX_W-1:0];
    end

    // Burst tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            size_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
        end else begin
            addr_q  <= addr_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
        end
    end

    assign beat_cnt     = beat_q;
    assign beat_cnt_nxt = beat_d;

endmodule

// File: rtl/axi_ddr_slave.sv
// AXI4 responder for the DDR port, backed by a MEM_WORDS x 32 register array.
// Latency: B one cycle after the last W beat; first R beat one cycle after AR.
// Backpressure: one burst in flight; AW/AR held off outside IDLE, R/B held until ready.
module axi_ddr_slave
    import axi_ddr_slave_pkg::*;
#(
    parameter int                          AXI_ADDR_WIDTH = 32,
    parameter int                          AXI_DATA_WIDTH = 32,
    parameter int                          AXI_ID_WIDTH   = 4,
    parameter int                          AXI_USER_WIDTH = 1,
    parameter int                          MEM_WORDS      = 1024,
    parameter logic [AXI_ADDR_WIDTH-1:0]   BASE_ADDR      = 32'h1000_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    // write address
    input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
    input  logic [7:0]                  aw_len,
    input  logic [2:0]                  aw_size,
    input  logic [1:0]                  aw_burst,
    input  logic [AXI_ID_WIDTH-1:0]     aw_id,
    input  logic [2:0]                  aw_prot,
    input  logic [3:0]                  aw_region,
    input  logic                        aw_lock,
    input  logic [3:0]                  aw_cache,
    input  logic [3:0]                  aw_qos,
    input  logic [AXI_USER_WIDTH-1:0]   aw_user,
    input  logic                        aw_valid,
    output logic                        aw_ready,
    // read address
    input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
    input  logic [7:0]                  ar_len,
    input  logic [2:0]                  ar_size,
    input  logic [1:0]                  ar_burst,
    input  logic [AXI_ID_WIDTH-1:0]     ar_id,
    input  logic [2:0]                  ar_prot,
    input  logic [3:0]                  ar_region,
    input  logic                        ar_lock,
    input  logic [3:0]                  ar_cache,
    input  logic [3:0]                  ar_qos,
    input  logic [AXI_USER_WIDTH-1:0]   ar_user,
    input  logic                        ar_valid,
    output logic                        ar_ready,
    // write data
    input  logic [AXI_DATA_WIDTH-1:0]   w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
    input  logic                        w_last,
    input  logic [AXI_USER_WIDTH-1:0]   w_user,
    input  logic                        w_valid,
    output logic                        w_ready,
    // read data
    output logic [AXI_DATA_WIDTH-1:0]   r_data,
    output logic [1:0]                  r_resp,
    output logic                        r_last,
    output logic [AXI_ID_WIDTH-1:0]     r_id,
    output logic [AXI_USER_WIDTH-1:0]   r_user,
    output logic                        r_valid,
    input  logic                        r_ready,
    // write response
    output logic [1:0]                  b_resp,
    output logic [AXI_ID_WIDTH-1:0]     b_id,
    output logic [AXI_USER_WIDTH-1:0]   b_user,
    output logic                        b_valid,
    input  logic                        b_ready
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(MEM_WORDS);

    logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    state_e                    state_q,    state_d;
    logic                      prio_w_q,   prio_w_d;
    logic [7:0]                len_q,      len_d;
    logic                      attr_err_q, attr_err_d;
    logic                      over_q,     over_d;
    logic [1:0]                acc_q,      acc_d;
    logic                      w_ready_q,  w_ready_d;
    logic                      b_valid_q,  b_valid_d;
    logic [1:0]                b_resp_q,   b_resp_d;
    logic [AXI_ID_WIDTH-1:0]   b_id_q,     b_id_d;
    logic                      r_valid_q,  r_valid_d;
    logic                      r_last_q,   r_last_d;
    logic [1:0]                r_resp_q,   r_resp_d;
    logic [AXI_ID_WIDTH-1:0]   r_id_q,     r_id_d;
    logic [AXI_DATA_WIDTH-1:0] r_data_q,   r_data_d;

    logic             idle;
    logic             aw_grant, ar_grant;
    logic             w_fire, r_fire, b_fire;
    logic             ag_load, ag_adv;
    logic [7:0]       beat_cnt, beat_cnt_nxt;
    logic             cur_hit, nxt_hit;
    logic [IDX_W-1:0] cur_idx, nxt_idx;
    logic [1:0]       acc_nxt;

    // Address-phase arbitration: the pointer only decides contested cycles,
    // so a lone requester is always granted and the two readies never overlap.
    always_comb begin
        idle     = (state_q == ST_IDLE) && !rst;
        aw_grant = idle && aw_valid && (prio_w_q || !ar_valid);
        ar_grant = idle && ar_valid && (!prio_w_q || !aw_valid);
        w_fire   = w_ready_q && !rst && w_valid;
        r_fire   = r_valid_q && r_ready;
        b_fire   = b_valid_q && b_ready;
        ag_load  = aw_grant || ar_grant;
        ag_adv   = w_fire || (r_fire && !r_last_q);
    end

    axi_ddr_slave_addr_gen #(
        .AW        (AXI_ADDR_WIDTH),
        .MEM_WORDS (MEM_WORDS),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .load         (ag_load),
        .adv          (ag_adv),
        .ld_addr      (aw_grant ? aw_addr  : ar_addr),
        .ld_size      (aw_grant ? aw_size  : ar_size),
        .ld_burst     (aw_grant ? aw_burst : ar_burst),
        .beat_cnt     (beat_cnt),
        .beat_cnt_nxt (beat_cnt_nxt),
        .cur_hit      (cur_hit),
        .cur_idx      (cur_idx),
        .nxt_hit      (nxt_hit),
        .nxt_idx      (nxt_idx)
    );

    // Transaction FSM next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        prio_w_d   = prio_w_q;
        len_d      = len_q;
        attr_err_d = attr_err_q;
        over_d     = over_q;
        acc_d      = acc_q;
        w_ready_d  = w_ready_q;
        b_valid_d  = b_valid_q;
        b_resp_d   = b_resp_q;
        b_id_d     = b_id_q;
        r_valid_d  = r_valid_q;
        r_last_d   = r_last_q;
        r_resp_d   = r_resp_q;
        r_id_d     = r_id_q;
        r_data_d   = r_data_q;
        acc_nxt    = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (aw_grant) begin
                    state_d    = ST_WDATA;
                    len_d      = aw_len;
                    b_id_d     = aw_id;
                    attr_err_d = attr_bad(aw_size, aw_burst);
                    over_d     = 1'b0;
                    acc_d      = RESP_OKAY;
                    w_ready_d  = 1'b1;
                    if (ar_valid) begin
                        prio_w_d = 1'b0;
                    end
                end else if (ar_grant) begin
                    state_d    = ST_RDATA;
                    len_d      = ar_len;
                    r_id_d     = ar_id;
                    attr_err_d = attr_bad(ar_size, ar_burst);
                    r_valid_d  = 1'b1;
                    r_data_d   = nxt_hit ? mem_q[nxt_idx] : '0;
                    r_resp_d   = beat_resp(nxt_hit, attr_err_d);
                    r_last_d   = (ar_len == 8'd0);
                    if (aw_valid) begin
                        prio_w_d = 1'b1;
                    end
                end
            end
            ST_WDATA: begin
                if (w_fire) begin
                    acc_nxt = resp_merge(acc_q, beat_resp(cur_hit, attr_err_q));
                    acc_d   = acc_nxt;
                    // Remember running past the announced length so a late
                    // w_last is still flagged even if the counter wraps.
                    over_d  = over_q || ((beat_cnt == len_q) && !w_last);
                    if (w_last) begin
                        state_d   = ST_WRESP;
                        w_ready_d = 1'b0;
                        b_valid_d = 1'b1;
                        b_resp_d  = resp_merge(acc_nxt,
                                    ((beat_cnt != len_q) || over_q) ? RESP_SLVERR : RESP_OKAY);
                    end
                end
            end
            ST_WRESP: begin
                if (b_fire) begin
                    state_d   = ST_IDLE;
                    b_valid_d = 1'b0;
                end
            end
            ST_RDATA: begin
                if (r_fire) begin
                    if (r_last_q) begin
                        state_d   = ST_IDLE;
                        r_valid_d = 1'b0;
                        r_last_d  = 1'b0;
                    end else begin
                        r_data_d = nxt_hit ? mem_q[nxt_idx] : '0;
                        r_resp_d = beat_resp(nxt_hit, attr_err_q);
                        r_last_d = (beat_cnt_nxt == len_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            prio_w_q   <= 1'b1;
            len_q      <= '0;
            attr_err_q <= 1'b0;
            over_q     <= 1'b0;
            acc_q      <= RESP_OKAY;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= '0;
            b_id_q     <= '0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_resp_q   <= '0;
            r_id_q     <= '0;
            r_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            prio_w_q   <= prio_w_d;
            len_q      <= len_d;
            attr_err_q <= attr_err_d;
            over_q     <= over_d;
            acc_q      <= acc_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
            b_id_q     <= b_id_d;
            r_valid_q  <= r_valid_d;
            r_last_q   <= r_last_d;
            r_resp_q   <= r_resp_d;
            r_id_q     <= r_id_d;
            r_data_q   <= r_data_d;
        end
    end

    // Storage array: byte-lane write on in-window W beats; never cleared.
    always_ff @(posedge clk) begin
        if (w_fire && cur_hit) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb[b]) begin
                    mem_q[cur_idx][b*8 +: 8] <= w_data[b*8 +: 8];
                end
            end
        end
    end

    assign aw_ready = aw_grant;
    assign ar_ready = ar_grant;
    assign w_ready  = w_ready_q && !rst;
    assign r_data   = r_data_q;
    assign r_resp   = r_resp_q;
    assign r_last   = r_last_q;
    assign r_id     = r_id_q;
    assign r_user   = '0;
    assign r_valid  = r_valid_q;
    assign b_resp   = b_resp_q;
    assign b_id     = b_id_q;
    assign b_user   = '0;
    assign b_valid  = b_valid_q;

    // Sideband fields carried by the protocol but with no meaning for this memory.
    logic unused_sideband;
    assign unused_sideband = ^{aw_prot, aw_region, aw_lock, aw_cache, aw_qos, aw_user,
                               ar_prot, ar_region, ar_lock, ar_cache, ar_qos, ar_user,
                               w_user};

endmodule

// File: tb/tb_axi_ddr_slave.sv
module tb_axi_ddr_slave;

    logic        clk;
    logic        rst;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic [3:0]  aw_id;
    logic        aw_valid, aw_ready;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic [3:0]  ar_id;
    logic        ar_valid, ar_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last, w_valid, w_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last, r_valid, r_ready;
    logic [3:0]  r_id;
    logic [0:0]  r_user;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    logic [0:0]  b_user;
    logic        b_valid, b_ready;

    int checks = 0;
    int errors = 0;

    axi_ddr_slave dut (
        .clk(clk), .rst(rst),
        .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst), .aw_id(aw_id),
        .aw_prot(3'd0), .aw_region(4'd0), .aw_lock(1'b0), .aw_cache(4'd0), .aw_qos(4'd0),
        .aw_user(1'b0), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst), .ar_id(ar_id),
        .ar_prot(3'd0), .ar_region(4'd0), .ar_lock(1'b0), .ar_cache(4'd0), .ar_qos(4'd0),
        .ar_user(1'b0), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_user(1'b0),
        .w_valid(w_valid), .w_ready(w_ready),
        .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_id(r_id), .r_user(r_user),
        .r_valid(r_valid), .r_ready(r_ready),
        .b_resp(b_resp), .b_id(b_id), .b_user(b_user), .b_valid(b_valid), .b_ready(b_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id);
        int n = 0;
        aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_id = id;
        aw_valid = 1'b1;
        #1;
        while (aw_ready !== 1'b1 && n < 50) begin tick(); n++; end
        chk("aw_ready_wait", {31'd0, aw_ready}, 32'd1);
        tick();
        aw_valid = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id);
        int n = 0;
        ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_id = id;
        ar_valid = 1'b1;
        #1;
        while (ar_ready !== 1'b1 && n < 50) begin tick(); n++; end
        chk("ar_ready_wait", {31'd0, ar_ready}, 32'd1);
        tick();
        ar_valid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
        #1;
        while (w_ready !== 1'b1 && n < 50) begin tick(); n++; end
        chk("w_ready_wait", {31'd0, w_ready}, 32'd1);
        tick();
        w_valid = 1'b0;
    endtask

    task automatic b_recv(output logic [1:0] resp, output logic [3:0] id);
        int n = 0;
        b_ready = 1'b1;
        #1;
        while (b_valid !== 1'b1 && n < 50) begin tick(); n++; end
        chk("b_valid_wait", {31'd0, b_valid}, 32'd1);
        resp = b_resp; id = b_id;
        tick();
        b_ready = 1'b0;
    endtask

    task automatic r_recv(output logic [31:0] data, output logic [1:0] resp, output logic last);
        int n = 0;
        r_ready = 1'b1;
        #1;
        while (r_valid !== 1'b1 && n < 50) begin tick(); n++; end
        chk("r_valid_wait", {31'd0, r_valid}, 32'd1);
        data = r_data; resp = r_resp; last = r_last;
        tick();
        r_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    logic [31:0] rd;
    logic [1:0]  rs;
    logic        rl;
    logic [3:0]  rid;

    initial begin
        rst = 1'b1;
        aw_addr = '0; aw_len = '0; aw_size = 3'd2; aw_burst = 2'b01; aw_id = '0; aw_valid = 1'b0;
        ar_addr = '0; ar_len = '0; ar_size = 3'd2; ar_burst = 2'b01; ar_id = '0; ar_valid = 1'b0;
        w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0;
        r_ready = 1'b0; b_ready = 1'b0;

        // Reset state, with both address valids raised to show readies stay low.
        tick(); tick();
        aw_valid = 1'b1; ar_valid = 1'b1;
        tick();
        chk("rst_aw_ready", {31'd0, aw_ready}, 32'd0);
        chk("rst_ar_ready", {31'd0, ar_ready}, 32'd0);
        chk("rst_w_ready",  {31'd0, w_ready},  32'd0);
        chk("rst_r_valid",  {31'd0, r_valid},  32'd0);
        chk("rst_b_valid",  {31'd0, b_valid},  32'd0);
        chk("rst_r_last",   {31'd0, r_last},   32'd0);
        chk("rst_r_data",   r_data,            32'd0);
        chk("rst_resps",    {28'd0, r_resp, b_resp}, 32'd0);
        chk("rst_ids",      {24'd0, r_id, b_id},     32'd0);
        aw_valid = 1'b0; ar_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Single write then read.
        aw_send(32'h1000_0010, 8'd0, 3'd2, 2'b01, 4'd3);
        w_send(32'hDEAD_BEEF, 4'hF, 1'b1);
        b_recv(rs, rid);
        chk("single_b_resp", {30'd0, rs}, 32'd0);
        chk("single_b_id",   {28'd0, rid}, 32'd3);
        ar_send(32'h1000_0010, 8'd0, 3'd2, 2'b01, 4'd5);
        chk("single_r_id", {28'd0, r_id}, 32'd5);
        r_recv(rd, rs, rl);
        chk("single_r_data", rd, 32'hDEAD_BEEF);
        chk("single_r_last", {31'd0, rl}, 32'd1);
        chk("single_r_resp", {30'd0, rs}, 32'd0);

        // INCR burst with read-side backpressure.
        aw_send(32'h1000_0000, 8'd3, 3'd2, 2'b01, 4'd1);
        for (int i = 0; i < 4; i++) w_send(32'(i + 1), 4'hF, (i == 3));
        b_recv(rs, rid);
        chk("incr_b_resp", {30'd0, rs}, 32'd0);
        ar_send(32'h1000_0000, 8'd3, 3'd2, 2'b01, 4'd2);
        for (int i = 0; i < 4; i++) begin
            chk("incr_r_data",  r_data, 32'(i + 1));
            chk("incr_r_last",  {31'd0, r_last}, (i == 3) ? 32'd1 : 32'd0);
            tick();
            chk("incr_stall_valid", {31'd0, r_valid}, 32'd1);
            chk("incr_stall_data",  r_data, 32'(i + 1));
            chk("incr_stall_last",  {31'd0, r_last}, (i == 3) ? 32'd1 : 32'd0);
            r_ready = 1'b1;
            tick();
            r_ready = 1'b0;
        end
        chk("incr_r_valid_done", {31'd0, r_valid}, 32'd0);

        // Byte strobes.
        aw_send(32'h1000_0020, 8'd0, 3'd2, 2'b01, 4'd0);
        w_send(32'h1122_3344, 4'hF, 1'b1);
        b_recv(rs, rid);
        aw_send(32'h1000_0020, 8'd0, 3'd2, 2'b01, 4'd0);
        w_send(32'hAABB_CCDD, 4'b0101, 1'b1);
        b_recv(rs, rid);
        ar_send(32'h1000_0020, 8'd0, 3'd2, 2'b01, 4'd0);
        r_recv(rd, rs, rl);
        chk("strb_r_data", rd, 32'h11BB_33DD);

        // Out of window: write dropped with DECERR, read returns zero.
        aw_send(32'h2000_0000, 8'd0, 3'd2, 2'b01, 4'd4);
        w_send(32'hCAFE_F00D, 4'hF, 1'b1);
        b_recv(rs, rid);
        chk("oor_b_resp", {30'd0, rs}, 32'd3);
        ar_send(32'h2000_0000, 8'd0, 3'd2, 2'b01, 4'd4);
        r_recv(rd, rs, rl);
        chk("oor_r_data", rd, 32'd0);
        chk("oor_r_resp", {30'd0, rs}, 32'd3);
        ar_send(32'h1000_0000, 8'd0, 3'd2, 2'b01, 4'd4);
        r_recv(rd, rs, rl);
        chk("oor_mem_unchanged", rd, 32'd1);

        // FIXED burst keeps writing the same word.
        aw_send(32'h1000_0050, 8'd1, 3'd2, 2'b00, 4'd6);
        w_send(32'h0000_0005, 4'hF, 1'b0);
        w_send(32'h0000_0006, 4'hF, 1'b1);
        b_recv(rs, rid);
        chk("fixed_b_resp", {30'd0, rs}, 32'd0);
        ar_send(32'h1000_0050, 8'd0, 3'd2, 2'b01, 4'd6);
        r_recv(rd, rs, rl);
        chk("fixed_r_data", rd, 32'd6);

        // Arbitration after reset: write wins first contest, read wins the next.
        do_reset();
        aw_addr = 32'h1000_0040; aw_len = 8'd3; aw_size = 3'd2; aw_burst = 2'b01; aw_id = 4'd7;
        ar_addr = 32'h1000_0040; ar_len = 8'd0; ar_size = 3'd2; ar_burst = 2'b01; ar_id = 4'd8;
        aw_valid = 1'b1; ar_valid = 1'b1;
        #1;
        chk("arb1_aw_ready", {31'd0, aw_ready}, 32'd1);
        chk("arb1_ar_ready", {31'd0, ar_ready}, 32'd0);
        tick();
        aw_valid = 1'b0;
        #1;
        chk("arb1_ar_blocked", {31'd0, ar_ready}, 32'd0);
        w_send(32'h0000_00A0, 4'hF, 1'b0);
        w_send(32'h0000_00A1, 4'hF, 1'b1);
        b_recv(rs, rid);
        chk("early_last_b_resp", {30'd0, rs}, 32'd2);
        chk("early_last_b_id",   {28'd0, rid}, 32'd7);
        chk("arb1_ar_after", {31'd0, ar_ready}, 32'd1);
        tick();
        ar_valid = 1'b0;
        r_recv(rd, rs, rl);
        chk("arb1_r_data", rd, 32'h0000_00A0);

        aw_addr = 32'h1000_0048; aw_len = 8'd0; aw_size = 3'd3; aw_burst = 2'b01; aw_id = 4'd9;
        ar_addr = 32'h1000_0044; ar_len = 8'd0; ar_size = 3'd2; ar_burst = 2'b01; ar_id = 4'd8;
        aw_valid = 1'b1; ar_valid = 1'b1;
        #1;
        chk("arb2_ar_ready", {31'd0, ar_ready}, 32'd1);
        chk("arb2_aw_ready", {31'd0, aw_ready}, 32'd0);
        tick();
        ar_valid = 1'b0;
        r_recv(rd, rs, rl);
        chk("arb2_r_data", rd, 32'h0000_00A1);
        chk("arb2_aw_after", {31'd0, aw_ready}, 32'd1);
        tick();
        aw_valid = 1'b0;
        w_send(32'h0000_0077, 4'hF, 1'b1);
        b_recv(rs, rid);
        chk("bigsize_b_resp", {30'd0, rs}, 32'd2);
        chk("bigsize_b_id",   {28'd0, rid}, 32'd9);

        // Reset during beat 2 of a len-7 read.
        aw_send(32'h1000_0080, 8'd7, 3'd2, 2'b01, 4'd2);
        for (int i = 0; i < 8; i++) w_send(32'h10 + 32'(i), 4'hF, (i == 7));
        b_recv(rs, rid);
        chk("len7_b_resp", {30'd0, rs}, 32'd0);
        ar_send(32'h1000_0080, 8'd7, 3'd2, 2'b01, 4'd2);
        r_recv(rd, rs, rl);
        chk("len7_beat0", rd, 32'h10);
        r_recv(rd, rs, rl);
        chk("len7_beat1", rd, 32'h11);
        chk("len7_beat2_pending", r_data, 32'h12);
        rst = 1'b1;
        tick();
        chk("midrst_r_valid", {31'd0, r_valid}, 32'd0);
        chk("midrst_r_data",  r_data, 32'd0);
        rst = 1'b0;
        tick();
        ar_addr = 32'h1000_0084; ar_len = 8'd0; ar_size = 3'd2; ar_burst = 2'b01; ar_id = 4'd1;
        ar_valid = 1'b1;
        #1;
        chk("midrst_ar_ready", {31'd0, ar_ready}, 32'd1);
        tick();
        ar_valid = 1'b0;
        r_recv(rd, rs, rl);
        chk("midrst_r_data_after", rd, 32'h11);
        chk("midrst_r_last_after", {31'd0, rl}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
